// File: rtl/apple_motion.sv
// apple_motion: per-object trajectory controller for the apple sprite.
// Arms when the kid enters a trigger box. Then it moves the apple along one axis
// with stepped acceleration until the sprite has fully left the 800x600 screen.
// All motion advances only on update_tick, and every output is registered.
// Optional build macro APPLE_MOTION_RESPAWN_EN: after leaving the screen, the
// block waits RESPAWN_TICKS ticks and then returns to IDLE by itself.
// Handshake note: there is no valid/ready pair here. update_tick is a bare
// one-clock strobe. restart is a level that wins over update_tick in the same clock.
module apple_motion #(
`ifdef APPLE_MOTION_RESPAWN_EN
    parameter int RESPAWN_TICKS = 60,
`endif
    parameter int INIT_X      = 400,
    parameter int INIT_Y      = 100,
    parameter int TRIG_X_LO   = 380,
    parameter int TRIG_X_HI   = 440,
    parameter int TRIG_Y_LO   = 0,
    parameter int TRIG_Y_HI   = 599,
    parameter int MOVE_DIR    = 0,
    parameter int V0          = 1,
    parameter int VMAX        = 8,
    parameter int ACC_DIV     = 4,
    parameter int DELAY_TICKS = 0,
    parameter int APPLE_W     = 22,
    parameter int APPLE_H     = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        update_tick,
    input  logic        restart,
    input  logic [9:0]  kid_x,
    input  logic [9:0]  kid_y,
    output logic [10:0] pos_x,
    output logic [10:0] pos_y,
    output logic        active,
    output logic        moving,
    output logic        triggered,
    output logic        done,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_MOVE = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic signed [10:0] INIT_X_S = 11'(INIT_X);
    localparam logic signed [10:0] INIT_Y_S = 11'(INIT_Y);
    localparam logic signed [10:0] W_S      = 11'(APPLE_W);
    localparam logic signed [10:0] H_S      = 11'(APPLE_H);
    localparam logic [6:0]         V0_S     = 7'(V0);
    localparam logic [6:0]         VMAX_S   = 7'(VMAX);
    localparam logic [7:0]         ACC_LAST = 8'(ACC_DIV - 1);
    localparam logic [15:0]        DLY_INIT = 16'(DELAY_TICKS);

    state_t             state_q, state_d;
    logic signed [10:0] pos_x_q, pos_x_d;
    logic signed [10:0] pos_y_q, pos_y_d;
    logic [6:0]         speed_q, speed_d;
    logic [7:0]         acc_q, acc_d;
    logic [15:0]        dly_q, dly_d;
    logic               active_q, active_d;
    logic               moving_q, moving_d;
    logic               trig_q, trig_d;
    logic               done_q, done_d;
`ifdef APPLE_MOTION_RESPAWN_EN
    localparam logic [15:0] RSP_INIT = 16'(RESPAWN_TICKS);
    logic [15:0]        rsp_q, rsp_d;
`endif

    // Candidate position for this tick and its off-screen test
    logic signed [10:0] step;
    logic signed [10:0] nx, ny, edge_sum;
    logic               off_screen;
    int                 kx, ky;
    logic               in_box;

    // Next-state, datapath and registered-output values
    always_comb begin
        state_d    = state_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        speed_d    = speed_q;
        acc_d      = acc_q;
        dly_d      = dly_q;
        trig_d     = 1'b0;
`ifdef APPLE_MOTION_RESPAWN_EN
        rsp_d      = rsp_q;
`endif
        step       = signed'({4'd0, speed_q});
        nx         = pos_x_q;
        ny         = pos_y_q;
        edge_sum   = '0;
        off_screen = 1'b0;

        // Only one axis moves; the other keeps its value.
        case (MOVE_DIR)
            0: begin
                ny         = pos_y_q + step;
                off_screen = (ny >= 11'sd600);
            end
            1: begin
                ny         = pos_y_q - step;
                edge_sum   = ny + H_S;
                off_screen = (edge_sum <= 11'sd0);
            end
            2: begin
                nx         = pos_x_q - step;
                edge_sum   = nx + W_S;
                off_screen = (edge_sum <= 11'sd0);
            end
            default: begin
                nx         = pos_x_q + step;
                off_screen = (nx >= 11'sd800);
            end
        endcase

        kx     = {22'd0, kid_x};
        ky     = {22'd0, kid_y};
        in_box = (kx >= TRIG_X_LO) && (kx <= TRIG_X_HI) &&
                 (ky >= TRIG_Y_LO) && (ky <= TRIG_Y_HI);

        if (restart) begin
            state_d = ST_IDLE;
            pos_x_d = INIT_X_S;
            pos_y_d = INIT_Y_S;
            speed_d = V0_S;
            acc_d   = '0;
            dly_d   = '0;
`ifdef APPLE_MOTION_RESPAWN_EN
            rsp_d   = '0;
`endif
        end else if (update_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_box) begin
                        trig_d = 1'b1;
                        if (DELAY_TICKS == 0) begin
                            state_d = ST_MOVE;
                        end else begin
                            state_d = ST_WAIT;
                            dly_d   = DLY_INIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (dly_q <= 16'd1) begin
                        dly_d   = '0;
                        state_d = ST_MOVE;
                    end else begin
                        dly_d = dly_q - 16'd1;
                    end
                end
                ST_MOVE: begin
                    pos_x_d = nx;
                    pos_y_d = ny;
                    if (acc_q == ACC_LAST) begin
                        acc_d   = '0;
                        speed_d = (speed_q >= VMAX_S) ? VMAX_S : speed_q + 7'd1;
                    end else begin
                        acc_d = acc_q + 8'd1;
                    end
                    if (off_screen) begin
                        state_d = ST_DONE;
`ifdef APPLE_MOTION_RESPAWN_EN
                        rsp_d   = RSP_INIT;
`endif
                    end
                end
                default: begin
`ifdef APPLE_MOTION_RESPAWN_EN
                    if (rsp_q <= 16'd1) begin
                        rsp_d   = '0;
                        state_d = ST_IDLE;
                        pos_x_d = INIT_X_S;
                        pos_y_d = INIT_Y_S;
                        speed_d = V0_S;
                        acc_d   = '0;
                        dly_d   = '0;
                    end else begin
                        rsp_d = rsp_q - 16'd1;
                    end
`endif
                end
            endcase
        end

        active_d = (state_d != ST_DONE);
        moving_d = (state_d == ST_MOVE);
        done_d   = (state_d == ST_DONE);
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pos_x_q  <= INIT_X_S;
            pos_y_q  <= INIT_Y_S;
            speed_q  <= V0_S;
            acc_q    <= '0;
            dly_q    <= '0;
            active_q <= 1'b1;
            moving_q <= 1'b0;
            trig_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef APPLE_MOTION_RESPAWN_EN
            rsp_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_x_q  <= pos_x_d;
            pos_y_q  <= pos_y_d;
            speed_q  <= speed_d;
            acc_q    <= acc_d;
            dly_q    <= dly_d;
            active_q <= active_d;
            moving_q <= moving_d;
            trig_q   <= trig_d;
            done_q   <= done_d;
`ifdef APPLE_MOTION_RESPAWN_EN
            rsp_q    <= rsp_d;
`endif
        end
    end

    assign pos_x     = pos_x_q;
    assign pos_y     = pos_y_q;
    assign active    = active_q;
    assign moving    = moving_q;
    assign triggered = trig_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_apple_motion.sv
// Directed bench for apple_motion. Instance a uses the default parameters and
// moves down. Instance b moves up, with a two-tick delay and V0 = 4.
module tb_apple_motion;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick_a = 1'b0, tick_b = 1'b0;
    logic        restart_a = 1'b0, restart_b = 1'b0;
    logic [9:0]  kid_x_a = 10'd100, kid_y_a = 10'd300;
    logic [9:0]  kid_x_b = 10'd0,   kid_y_b = 10'd300;
    logic [10:0] pos_x_a, pos_y_a, pos_x_b, pos_y_b;
    logic        active_a, moving_a, trig_a, done_a;
    logic        active_b, moving_b, trig_b, done_b;
    logic [1:0]  st_a, st_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Clock and reset
    always #5 clk = ~clk;

    apple_motion #(
`ifdef APPLE_MOTION_RESPAWN_EN
        .RESPAWN_TICKS(3)
`endif
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .update_tick(tick_a), .restart(restart_a),
        .kid_x(kid_x_a), .kid_y(kid_y_a), .pos_x(pos_x_a), .pos_y(pos_y_a),
        .active(active_a), .moving(moving_a), .triggered(trig_a), .done(done_a),
        .dbg_state(st_a)
    );

    apple_motion #(
        .INIT_Y(10), .MOVE_DIR(1), .DELAY_TICKS(2), .V0(4)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .update_tick(tick_b), .restart(restart_b),
        .kid_x(kid_x_b), .kid_y(kid_y_b), .pos_x(pos_x_b), .pos_y(pos_y_b),
        .active(active_b), .moving(moving_b), .triggered(trig_b), .done(done_b),
        .dbg_state(st_b)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Driver tasks: strobe for one clock, return on the following negedge
    task automatic pulse_a();
        @(negedge clk); tick_a = 1'b1;
        @(negedge clk); tick_a = 1'b0;
    endtask

    task automatic pulse_b();
        @(negedge clk); tick_b = 1'b1;
        @(negedge clk); tick_b = 1'b0;
    endtask

    function automatic int sy_a();
        return int'($signed(pos_y_a));
    endfunction

    function automatic int sy_b();
        return int'($signed(pos_y_b));
    endfunction

    int exp_y_a[9] = '{101, 102, 103, 104, 106, 108, 110, 112, 115};
    int exp_y_b[8] = '{6, 2, -2, -6, -11, -16, -21, -26};
    int trig_seen;

    initial begin
        // Reset and idle
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        check("reset_pos_x", int'($signed(pos_x_a)), 400);
        check("reset_pos_y", sy_a(), 100);
        check("reset_active", active_a, 1);
        check("reset_done", done_a, 0);
        check("reset_state", st_a, 0);
        trig_seen = 0;
        for (int i = 0; i < 10; i++) begin
            pulse_a();
            if (trig_a) trig_seen++;
        end
        check("idle_no_trigger", trig_seen, 0);
        check("idle_pos_y", sy_a(), 100);
        check("idle_moving", moving_a, 0);
        // Just outside the box on both sides of x
        kid_x_a = 10'd441; pulse_a();
        check("box_441_out", trig_a, 0);
        kid_x_a = 10'd379; pulse_a();
        check("box_379_out", trig_a, 0);

        // Trigger and acceleration, moving down
        kid_x_a = 10'd400;
        pulse_a();
        check("t1_triggered", trig_a, 1);
        check("t1_pos_y", sy_a(), 100);
        check("t1_moving", moving_a, 1);
        kid_x_a = 10'd0;  // ignored outside IDLE
        @(negedge clk);
        check("trig_one_clk", trig_a, 0);
        for (int i = 0; i < 9; i++) begin
            pulse_a();
            check($sformatf("down_t%0d_y", i + 2), sy_a(), exp_y_a[i]);
            check("down_x_fixed", int'($signed(pos_x_a)), 400);
        end
        for (int t = 11; t <= 77; t++) begin
            pulse_a();
            if (t == 29) check("down_t29_y", sy_a(), 212);
            if (t == 34) check("vmax_cap_t34_y", sy_a(), 252);
        end
        check("t77_y", sy_a(), 596);
        check("t77_done", done_a, 0);
        pulse_a();
        check("exit_y", sy_a(), 604);
        check("exit_done", done_a, 1);
        check("exit_active", active_a, 0);
        check("exit_moving", moving_a, 0);
        check("exit_x", int'($signed(pos_x_a)), 400);
        kid_x_a = 10'd400;
        repeat (2) pulse_a();
        check("frozen_y", sy_a(), 604);
        check("frozen_done", done_a, 1);
        pulse_a();
`ifdef APPLE_MOTION_RESPAWN_EN
        check("respawn_active", active_a, 1);
        check("respawn_done", done_a, 0);
        check("respawn_y", sy_a(), 100);
        check("respawn_x", int'($signed(pos_x_a)), 400);
        pulse_a();
        check("respawn_retrigger", trig_a, 1);
`else
        check("terminal_done", done_a, 1);
        check("terminal_y", sy_a(), 604);
`endif

        // Restart from wherever the block is, then retrigger at the low x edge
        @(negedge clk); restart_a = 1'b1;
        @(negedge clk); restart_a = 1'b0;
        check("restart_y", sy_a(), 100);
        check("restart_done", done_a, 0);
        check("restart_active", active_a, 1);
        check("restart_state", st_a, 0);
        kid_x_a = 10'd380;
        pulse_a();
        check("box_380_in", trig_a, 1);
        for (int i = 0; i < 6; i++) pulse_a();
        check("pre_restart_y", sy_a(), 108);

        // Restart and update_tick together in MOVE: restart wins
        @(negedge clk); restart_a = 1'b1; tick_a = 1'b1;
        @(negedge clk); restart_a = 1'b0; tick_a = 1'b0;
        check("rs_prio_y", sy_a(), 100);
        check("rs_prio_x", int'($signed(pos_x_a)), 400);
        check("rs_prio_moving", moving_a, 0);
        check("rs_prio_state", st_a, 0);
        kid_x_a = 10'd440;
        pulse_a();
        check("box_440_in", trig_a, 1);
        pulse_a();
        check("rs_speed_v0_y", sy_a(), 101);
        repeat (3) pulse_a();
        check("rs_m4_y", sy_a(), 104);
        pulse_a();
        check("rs_m5_y", sy_a(), 106);

        // Delay and upward motion on instance b
        kid_x_b = 10'd400;
        pulse_b();
        check("b_triggered", trig_b, 1);
        check("b_wait_state", st_b, 1);
        check("b_t1_y", sy_b(), 10);
        kid_x_b = 10'd0;
        pulse_b();
        check("b_t2_y", sy_b(), 10);
        check("b_t2_moving", moving_b, 0);
        pulse_b();
        check("b_t3_y", sy_b(), 10);
        check("b_t3_moving", moving_b, 1);
        for (int i = 0; i < 8; i++) begin
            pulse_b();
            check($sformatf("up_m%0d_y", i + 1), sy_b(), exp_y_b[i]);
            check($sformatf("up_m%0d_done", i + 1), done_b, (i == 7) ? 1 : 0);
        end
        check("b_raw_bits", pos_y_b, 11'h7E6);
        check("b_active", active_b, 0);
        check("b_x_fixed", int'($signed(pos_x_b)), 400);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/apple_motion.md
Name: apple_motion

Overview:
- Per-object trajectory controller sitting directly upstream of the apple sprite renderer.
- Watches the kid position once per frame, arms when the kid enters a trigger box, then moves the apple in one fixed direction with stepped acceleration until it leaves the 800x600 screen.
- Drives the renderer's pos_x/pos_y plus status flags used by the collision and scene logic.

Parameters:
- INIT_X, 400: reset/restart x of apple top-left, pixels.
- INIT_Y, 100: reset/restart y of apple top-left, pixels.
- TRIG_X_LO, 380: trigger box, inclusive lower kid_x.
- TRIG_X_HI, 440: trigger box, inclusive upper kid_x.
- TRIG_Y_LO, 0: trigger box, inclusive lower kid_y.
- TRIG_Y_HI, 599: trigger box, inclusive upper kid_y.
- MOVE_DIR, 0: 0 down (+y), 1 up (-y), 2 left (-x), 3 right (+x).
- V0, 1: initial speed, pixels per tick.
- VMAX, 8: speed ceiling.
- ACC_DIV, 4: moves per +1 speed step.
- DELAY_TICKS, 0: ticks between trigger and first move.
- APPLE_W, 22: sprite width.
- APPLE_H, 24: sprite height.

Ports:
- clk  in  1  system clock, same domain as renderer.
- rst_n  in  1  synchronous active-low reset.
- update_tick  in  1  one-clk pulse per frame; all motion advances only on this.
- restart  in  1  synchronous return to IDLE at init position.
- kid_x  in  10  kid x, unsigned pixels.
- kid_y  in  10  kid y, unsigned pixels.
- pos_x  out  11  signed two's-complement apple x.
- pos_y  out  11  signed two's-complement apple y.
- active  out  1  apple visible (high in IDLE, WAIT and MOVE).
- moving  out  1  high in MOVE.
- triggered  out  1  one-clk pulse on the trigger transition.
- done  out  1  high in DONE.

Behaviour:
- Reset (rst_n low at clk edge): state IDLE, pos_x=INIT_X, pos_y=INIT_Y, speed=V0, acc_cnt=0, dly_cnt=0, active=1, moving=0, triggered=0, done=0. Reset has priority over everything.
- restart high (not in reset): identical to reset. It beats a simultaneous update_tick.
- All outputs are registered. Updates take effect the clk after the update_tick edge; no change between ticks.
- IDLE: on tick, if TRIG_X_LO<=kid_x<=TRIG_X_HI and TRIG_Y_LO<=kid_y<=TRIG_Y_HI:
  - pulse triggered for 1 clk.
  - go to WAIT with dly_cnt=DELAY_TICKS, or directly to MOVE if DELAY_TICKS=0.
  - No movement on the trigger tick.
- WAIT: each tick decrement dly_cnt; when it reaches 0 go to MOVE. No movement during WAIT.
- MOVE, each tick:
  - Step the axis by speed in the MOVE_DIR sign, in 11-bit signed arithmetic.
  - Then increment acc_cnt. When acc_cnt==ACC_DIV-1: speed=min(speed+1,VMAX), acc_cnt=0.
- Off-screen test on the newly computed position, same tick:
  - down: pos_y>=600.
  - up: pos_y+APPLE_H<=0.
  - left: pos_x+APPLE_W<=0.
  - right: pos_x>=800.
  - If true: commit the new position, go to DONE, active=0, moving=0, done=1.
- DONE: position frozen; ignores kid and ticks; leaves only via restart or reset.
- Off-axis coordinate never changes.
- Overflow: with VMAX<=64 and on-screen start, the off-screen stop prevents 11-bit wrap. Larger VMAX is unsupported.
- Trigger box is evaluated only in IDLE; kid movement in other states is ignored.

Optional Feature:
- Macro: APPLE_MOTION_RESPAWN_EN.
- Defined: adds parameter RESPAWN_TICKS (default 60). On entering DONE, a counter loads RESPAWN_TICKS. Each tick decrements it; at 0 the block auto-returns to IDLE with init position/speed, active=1, done=0. restart still works at any time.
- Undefined: DONE is terminal until restart/reset; no counter logic is synthesized.

Test Plan:
- Reset/idle: rst_n low 2 clks, kid_x=100, 10 ticks -> pos=(400,100), active=1, moving=0, triggered never pulses.
- Trigger and acceleration: kid_x=400, kid_y=300, then ticks:
  - tick1 -> one triggered pulse, pos_y=100.
  - ticks2-5 -> pos_y 101,102,103,104.
  - ticks6-9 -> 106,108,110,112.
  - tick10 -> 115.
  - pos_x stays 400 throughout.
- Exit bottom: continue ticking -> done=1 and active=0 on the first tick with pos_y>=600. Further ticks leave pos unchanged.
- Delay plus direction up: MOVE_DIR=1, INIT_Y=10, DELAY_TICKS=2, V0=4:
  - trigger, then 2 idle ticks (pos_y=10), then pos_y 6, 2, -2, ...
  - done once pos_y+24<=0; pos_y reads as a negative two's-complement value.
- Restart priority: restart and update_tick asserted together mid-MOVE -> next clk pos=(400,100), IDLE, speed=V0, no step applied.
- Respawn (APPLE_MOTION_RESPAWN_EN, RESPAWN_TICKS=3): after done -> 3 ticks later active=1, done=0, pos=(400,100), re-triggerable.
